// File: rtl/hamming_decoder_engine.sv
// SEC-DED Hamming decoder engine: reads encoded 16-bit words, corrects single errors, flags doubles.
// Define HAMMING_STATS_EN to add saturating single/double error counters.
module hamming_decoder_engine #(
    parameter int NUM_WORDS = 15,
    parameter int SRC_BASE  = 30,
    parameter int DST_BASE  = 0,
    parameter int ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
`ifdef HAMMING_STATS_EN
    ,
    output logic [4:0]        single_cnt,
    output logic [4:0]        double_cnt
`endif
);

    localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        DECODE,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]  idx;
    logic [7:0]        raw_lo, raw_hi;
    logic [7:0]        out_lo, out_hi;
    logic [15:0]       word, fixed;
    logic [3:0]        syn;
    logic              par;
    logic              f0, f1;
    logic [10:0]       data;
    logic              start;
    logic              last;
    logic [ADDR_W-1:0] off;
    logic [ADDR_W-1:0] src_addr, dst_addr;

    assign start    = req && ((state == IDLE) || (state == DONE));
    assign last     = (idx == IDX_W'(NUM_WORDS - 1));
    assign off      = ADDR_W'(idx) << 1;
    assign src_addr = ADDR_W'(SRC_BASE) + off;
    assign dst_addr = ADDR_W'(DST_BASE) + off;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = RD_LO;
            RD_LO:   state_nxt = RD_HI;
            RD_HI:   state_nxt = DECODE;
            DECODE:  state_nxt = WR_LO;
            WR_LO:   state_nxt = WR_HI;
            WR_HI:   state_nxt = last ? DONE : RD_LO;
            DONE:    if (req) state_nxt = RD_LO;
            default: state_nxt = IDLE;
        endcase
    end

    // Memory bus is driven straight from the state so reset silences it immediately.
    always_comb begin
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = 8'h00;
        case (state)
            RD_LO: mem_addr = src_addr;
            RD_HI: mem_addr = src_addr + ADDR_W'(1);
            WR_LO: begin
                mem_addr    = dst_addr;
                mem_wr_en   = 1'b1;
                mem_wr_data = out_lo;
            end
            WR_HI: begin
                mem_addr    = dst_addr + ADDR_W'(1);
                mem_wr_en   = 1'b1;
                mem_wr_data = out_hi;
            end
            default: ;
        endcase
    end

    // Syndrome is the XOR of the positions of all set bits; overall parity picks single vs double.
    always_comb begin
        word = {raw_hi, raw_lo};
        syn  = 4'd0;
        for (int k = 1; k < 16; k++) begin
            if (word[k]) syn = syn ^ 4'(k);
        end
        par   = ^word;
        fixed = word;
        f0    = 1'b0;
        f1    = 1'b0;
        if (par) begin
            fixed[syn] = ~fixed[syn];
            f0         = 1'b1;
        end else if (syn != 4'd0) begin
            f1 = 1'b1;
        end
        data = {fixed[15:9], fixed[7:5], fixed[3]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx    <= '0;
            raw_lo <= 8'h00;
            raw_hi <= 8'h00;
            out_lo <= 8'h00;
            out_hi <= 8'h00;
            done   <= 1'b0;
        end else begin
            done <= (state == DONE) && !req;
            if (start) begin
                idx <= '0;
            end else if ((state == WR_HI) && !last) begin
                idx <= idx + 1'b1;
            end
            if (state == RD_LO) raw_lo <= mem_rd_data;
            if (state == RD_HI) raw_hi <= mem_rd_data;
            if (state == DECODE) begin
                out_lo <= data[7:0];
                out_hi <= {f1, f0, 3'b000, data[10:8]};
            end
        end
    end

`ifdef HAMMING_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            single_cnt <= 5'd0;
            double_cnt <= 5'd0;
        end else if (start) begin
            single_cnt <= 5'd0;
            double_cnt <= 5'd0;
        end else if (state == DECODE) begin
            if (f0 && (single_cnt != 5'd31)) single_cnt <= single_cnt + 5'd1;
            if (f1 && (double_cnt != 5'd31)) double_cnt <= double_cnt + 5'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hamming_decoder_engine.sv
// Scoreboard bench for hamming_decoder_engine: a behavioural decoder predicts every memory write.
module tb_hamming_decoder_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       req;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
`ifdef HAMMING_STATS_EN
    logic [4:0] single_cnt;
    logic [4:0] double_cnt;
`endif

    logic [7:0]  mem [256];
    logic [15:0] src_words [15];
    logic [15:0] exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          exp_single;
    int          exp_double;

    always #5 clk = ~clk;

    hamming_decoder_engine dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
`ifdef HAMMING_STATS_EN
        ,
        .single_cnt  (single_cnt),
        .double_cnt  (double_cnt)
`endif
    );

    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference: returns {high byte, low byte} computed from the code's definition.
    function automatic logic [15:0] ref_decode(input logic [15:0] w);
        int         s = 0;
        int         ones = 0;
        int         dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [15:0] c;
        logic [10:0] d;
        logic        f0 = 1'b0;
        logic        f1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (w[k]) begin
                ones++;
                if (k > 0) s = s ^ k;
            end
        end
        c = w;
        if (ones % 2 == 1) begin
            c[s] = ~c[s];
            f0   = 1'b1;
        end else if (s != 0) begin
            f1 = 1'b1;
        end
        for (int j = 0; j < 11; j++) d[j] = c[dpos[j]];
        return {f1, f0, 3'b000, d[10:8], d[7:0]};
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        int          dpos [11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        logic [15:0] w = 16'h0000;
        logic [3:0]  s = 4'd0;
        for (int j = 0; j < 11; j++) w[dpos[j]] = d[j];
        for (int k = 1; k < 16; k++) if (w[k]) s = s ^ 4'(k);
        w[1] = s[0];
        w[2] = s[1];
        w[4] = s[2];
        w[8] = s[3];
        w[0] = ^w[15:1];
        return w;
    endfunction

    function automatic logic [15:0] random_word();
        logic [15:0] w = encode(11'($urandom_range(0, 2047)));
        int          n = $urandom_range(0, 2);
        int          a = $urandom_range(0, 15);
        int          b = (a + $urandom_range(1, 15)) % 16;
        if (n >= 1) w[a] = ~w[a];
        if (n == 2) w[b] = ~w[b];
        return w;
    endfunction

    // Monitor: every write the DUT performs must match the oldest prediction.
    always @(negedge clk) begin
        logic [15:0] e;
        if (!reset && mem_wr_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", mem_addr, mem_wr_data);
            end else begin
                e = exp_q.pop_front();
                check("write", {16'h0, mem_addr, mem_wr_data}, {16'h0, e});
            end
        end
    end

    task automatic load_and_predict();
        logic [15:0] r;
        exp_single = 0;
        exp_double = 0;
        for (int i = 0; i < 15; i++) begin
            mem[30 + 2 * i]     <= src_words[i][7:0];
            mem[30 + 2 * i + 1] <= src_words[i][15:8];
            r = ref_decode(src_words[i]);
            exp_q.push_back({8'(2 * i), r[7:0]});
            exp_q.push_back({8'(2 * i + 1), r[15:8]});
            if (r[14]) exp_single++;
            if (r[15]) exp_double++;
        end
        if (exp_single > 31) exp_single = 31;
        if (exp_double > 31) exp_double = 31;
        @(negedge clk);
    endtask

    // Issues req, waits for done within a cycle budget, optionally pulses req mid-pass.
    task automatic apply_stimulus(input int pulse_at);
        int n = 0;
        load_and_predict();
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        while (!done && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            req = (n == pulse_at);
        end
        req = 1'b0;
        check("done_latency", n, 76);
        check("all_writes_seen", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("done_held", done, 1);
        check("no_write_in_done", mem_wr_en, 0);
`ifdef HAMMING_STATS_EN
        check("single_cnt", single_cnt, exp_single);
        check("double_cnt", double_cnt, exp_double);
`endif
    endtask

    task automatic check_output(input string name, input int addr, input logic [7:0] expected);
        check(name, mem[addr], expected);
    endtask

    task automatic fill_random_clean();
        for (int i = 0; i < 15; i++) src_words[i] = encode(11'($urandom_range(0, 2047)));
    endtask

    initial begin
        int nz;
        reset = 1'b1;
        req   = 1'b0;
        for (int a = 0; a < 256; a++) mem[a] <= 8'h00;
        #12;
        check("reset_done", done, 0);
        check("reset_wr_en", mem_wr_en, 0);
        check("reset_addr", mem_addr, 0);
        check("reset_wr_data", mem_wr_data, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) src_words[i] = 16'h0000;
        apply_stimulus(-1);
        nz = 0;
        for (int a = 0; a < 30; a++) if (mem[a] != 8'h00) nz++;
        check("zero_dest_bytes", nz, 0);

        fill_random_clean();
        src_words[0] = 16'hFFFF;
        apply_stimulus(-1);
        check_output("clean_lo", 0, 8'hFF);
        check_output("clean_hi", 1, 8'h07);

        fill_random_clean();
        src_words[0] = 16'hFFDF;
        apply_stimulus(-1);
        check_output("d2_fix_lo", 0, 8'hFF);
        check_output("d2_fix_hi", 1, 8'h47);

        fill_random_clean();
        src_words[0] = 16'hFFFE;
        apply_stimulus(-1);
        check_output("p0_fix_lo", 0, 8'hFF);
        check_output("p0_fix_hi", 1, 8'h47);

        fill_random_clean();
        src_words[0] = 16'hFDDF;
        apply_stimulus(-1);
        check_output("double_lo", 0, 8'hED);
        check_output("double_hi", 1, 8'h87);
`ifdef HAMMING_STATS_EN
        check("double_cnt_one", double_cnt, 1);
`endif

        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 15; i++) src_words[i] = random_word();
            apply_stimulus(-1);
        end

        // Abort a pass while the fourth word's high byte is being written.
        for (int i = 0; i < 15; i++) src_words[i] = random_word();
        load_and_predict();
        req = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        check("pre_reset_wr_en", mem_wr_en, 1);
        reset = 1'b1;
        #1;
        check("abort_done", done, 0);
        check("abort_wr_en", mem_wr_en, 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) src_words[i] = random_word();
        apply_stimulus(37);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/hamming_decoder_engine.md
Name: hamming_decoder_engine

Overview:
- Hardware SEC-DED Hamming decoder; the receive-side counterpart of the program-1 parity encoder.
- Triggered by a req/done handshake from the top level.
- Reads NUM_WORDS encoded 16-bit words from data memory, corrects single-bit errors and flags double-bit errors.
- Writes recovered 11-bit messages plus status flags back to data memory.
- Sits beside the core as a memory-bus master, arbitrated in at top_level.

Parameters:
- NUM_WORDS, 15: number of encoded words processed per request.
- SRC_BASE, 30: byte address of the first encoded word's low byte.
- DST_BASE, 0: byte address of the first decoded word's low byte.
- ADDR_W, 8: memory byte-address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  start pulse, sampled on the rising edge of clk.
- done  output  1  high when a pass is complete; held until the next accepted req.
- mem_addr  output  ADDR_W  byte address for the current read or write.
- mem_rd_data  input  8  combinational read data for mem_addr, valid in the same cycle.
- mem_wr_en  output  1  byte write strobe; memory writes on the rising edge while high.
- mem_wr_data  output  8  byte write data.

Interface: one clock (clk); reset is asynchronous and active-high.

Behaviour:
- Reset (async): state IDLE, done=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, word index=0. Takes effect immediately, including mid-pass; a write in progress is dropped.
- Source layout:
  - Word i low byte is at SRC_BASE+2i, high byte at SRC_BASE+2i+1.
  - 16-bit word bit k is Hamming position k (k = 1..15); bit 0 is the overall parity p0.
  - Parity positions: p1=bit1, p2=bit2, p4=bit4, p8=bit8.
  - Data positions: d1=bit3, d4..d2=bits7..5, d11..d5=bits15..9.
- Decode rules:
  - Syndrome s (4 bits) = XOR of the indices k of all set bits, k = 1..15.
  - P = XOR of all 16 bits.
  - s=0, P=0: clean; F1=0, F0=0.
  - P=1: single error at position s (s=0 means p0 itself); flip that bit; F0=1, F1=0.
  - s!=0, P=0: double error; data is output uncorrected; F1=1, F0=0.
- Destination layout:
  - Low byte at DST_BASE+2i = {d8..d1}.
  - High byte at DST_BASE+2i+1 = {F1, F0, 3'b000, d11, d10, d9}.
- State machine, one state per cycle:
  - IDLE -> RD_LO when req=1.
  - RD_LO: latch low byte from SRC_BASE+2i.
  - RD_HI: latch high byte from SRC_BASE+2i+1.
  - DECODE: register syndrome, corrected data and flags.
  - WR_LO: mem_wr_en=1, writes DST_BASE+2i.
  - WR_HI: mem_wr_en=1, writes DST_BASE+2i+1. If i = NUM_WORDS-1, go to DONE; otherwise increment i and go to RD_LO.
  - DONE: done=1. req=1 clears done, resets i=0 and goes to RD_LO.
- Latency:
  - 5 cycles per word.
  - With req sampled at edge E, done rises at edge E+5*NUM_WORDS+1 (E+76 at default).
- Boundary conditions:
  - req is ignored in every state except IDLE and DONE.
  - mem_wr_en is 0 outside WR_LO and WR_HI.
  - The index never wraps within a pass.
  - Address arithmetic is modulo 2^ADDR_W.
  - Overlapping source and destination ranges are legal: each word is fully read before either of its bytes is written.

Optional Feature:
- Macro: HAMMING_STATS_EN.
- When defined, adds outputs single_cnt [4:0] and double_cnt [4:0].
  - Counters clear on reset and on each accepted req.
  - Each increments in DECODE when F0 or F1, respectively, is set.
  - Counters saturate at 31 and hold their values while done=1.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- All 15 source words 16'h0000 -> every destination byte is 8'h00; done rises 76 cycles after the req edge.
- Word 0 = 16'hFFFF (data 11'h7FF, clean) -> byte 0 = 8'hFF, byte 1 = 8'h07.
- Word 0 = 16'hFFDF (d2 flipped) -> byte 0 = 8'hFF, byte 1 = 8'h47 (corrected, F0 set).
- Word 0 = 16'hFFFE (p0 flipped) -> byte 0 = 8'hFF, byte 1 = 8'h47.
- Word 0 = 16'hFDDF (bits 5 and 9 flipped) -> byte 0 = 8'hED, byte 1 = 8'h87 (F1 set, uncorrected). With HAMMING_STATS_EN: double_cnt=1.
- Assert reset at cycle 20 of a pass -> done=0 and mem_wr_en=0 immediately. A new req completes a full pass with correct outputs. req pulsed mid-pass has no effect.
